// File: rtl/arb_2to1_vector_if.sv
// Stream bundle between two sources, the arbiter and its sink.
// The arbiter uses the slave modport; the driving environment uses master.
interface arb_2to1_vector_if #(
    parameter int unsigned VECTOR_LEN = 16
) ();
    logic [VECTOR_LEN-1:0] a_data;
    logic                  a_valid;
    logic                  a_ready;
    logic [VECTOR_LEN-1:0] b_data;
    logic                  b_valid;
    logic                  b_ready;
    logic [VECTOR_LEN-1:0] y_data;
    logic                  y_valid;
    logic                  y_ready;
    logic                  sel;

    modport slave (
        input  a_data, a_valid, b_data, b_valid, y_ready,
        output a_ready, b_ready, y_data, y_valid, sel
    );

    modport master (
        output a_data, a_valid, b_data, b_valid, y_ready,
        input  a_ready, b_ready, y_data, y_valid, sel
    );
endinterface

// File: rtl/arb_2to1_vector.sv
// Registered 2-input round-robin stream arbiter feeding mux_2to1_vector.
// sel encodes the source of y_data: 1 = a, 0 = b.
module arb_2to1_vector #(
    parameter int unsigned VECTOR_LEN = 16
) (
    input logic              clk,
    input logic              rst,
    arb_2to1_vector_if.slave bus
);
    logic [VECTOR_LEN-1:0] y_data_q, y_data_d;
    logic                  y_valid_q, y_valid_d;
    logic                  sel_q, sel_d;
    logic                  last_sel_q, last_sel_d;
    logic                  load;
    logic                  a_ready, b_ready;
    logic                  grant_a, grant_b;

    // Readiness depends only on the competing source, never on the own valid.
    always_comb begin
        load    = !y_valid_q || bus.y_ready;
        a_ready = load && (!bus.b_valid || !last_sel_q);
        b_ready = load && (!bus.a_valid || last_sel_q);
        grant_a = bus.a_valid && a_ready;
        grant_b = bus.b_valid && b_ready;
    end

    always_comb begin
        y_data_d   = y_data_q;
        y_valid_d  = y_valid_q;
        sel_d      = sel_q;
        last_sel_d = last_sel_q;
        if (load) begin
            if (grant_a) begin
                y_data_d   = bus.a_data;
                y_valid_d  = 1'b1;
                sel_d      = 1'b1;
                last_sel_d = 1'b1;
            end else if (grant_b) begin
                y_data_d   = bus.b_data;
                y_valid_d  = 1'b1;
                sel_d      = 1'b0;
                last_sel_d = 1'b0;
            end else begin
                // Idle: drop valid but keep data/sel stable for the mux.
                y_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_data_q   <= '0;
            y_valid_q  <= 1'b0;
            sel_q      <= 1'b0;
            last_sel_q <= 1'b0;
        end else begin
            y_data_q   <= y_data_d;
            y_valid_q  <= y_valid_d;
            sel_q      <= sel_d;
            last_sel_q <= last_sel_d;
        end
    end

    assign bus.a_ready = a_ready;
    assign bus.b_ready = b_ready;
    assign bus.y_data  = y_data_q;
    assign bus.y_valid = y_valid_q;
    assign bus.sel     = sel_q;
endmodule

// File: tb/tb_arb_2to1_vector.sv
// Directed-vector bench for arb_2to1_vector with hand-computed expectations.
module tb_arb_2to1_vector;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    arb_2to1_vector_if #(.VECTOR_LEN(16)) bus ();

    arb_2to1_vector #(.VECTOR_LEN(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        bus.a_data  = 16'h0000;
        bus.b_data  = 16'h0000;
    endtask

    task automatic test_reset();
        bus.a_valid = 1'b1;
        bus.a_data  = 16'h1111;
        bus.y_ready = 1'b1;
        step();
        idle_inputs();
        bus.y_ready = 1'b0;
        #1;
        checks++;
        if (bus.y_valid !== 1'b1 || bus.y_data !== 16'h1111) begin
            failures++;
            $display("FAIL reset_preload: valid=%b data=%h required valid=1 data=1111",
                     bus.y_valid, bus.y_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.y_valid !== 1'b0 || bus.y_data !== 16'h0000 || bus.sel !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: valid=%b data=%h sel=%b required 0/0000/0",
                     bus.y_valid, bus.y_data, bus.sel);
        end
        step();
        rst = 1'b0;
        bus.y_ready = 1'b1;
        step();
        step();
        checks++;
        if (bus.y_valid !== 1'b0 || bus.y_data !== 16'h0000 || bus.sel !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: valid=%b data=%h sel=%b required 0/0000/0",
                     bus.y_valid, bus.y_data, bus.sel);
        end
    endtask

    task automatic test_single();
        bus.a_valid = 1'b1;
        bus.a_data  = 16'h1234;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_a_ready: a_ready=%b required 1", bus.a_ready);
        end
        step();
        idle_inputs();
        checks++;
        if (bus.y_valid !== 1'b1 || bus.y_data !== 16'h1234 || bus.sel !== 1'b1) begin
            failures++;
            $display("FAIL single_a: valid=%b data=%h sel=%b required 1/1234/1",
                     bus.y_valid, bus.y_data, bus.sel);
        end
        bus.b_valid = 1'b1;
        bus.b_data  = 16'hABCD;
        #1;
        checks++;
        if (bus.b_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_b_ready: b_ready=%b required 1", bus.b_ready);
        end
        step();
        idle_inputs();
        checks++;
        if (bus.y_valid !== 1'b1 || bus.y_data !== 16'hABCD || bus.sel !== 1'b0) begin
            failures++;
            $display("FAIL single_b: valid=%b data=%h sel=%b required 1/abcd/0",
                     bus.y_valid, bus.y_data, bus.sel);
        end
        step();
        checks++;
        if (bus.y_valid !== 1'b0 || bus.y_data !== 16'hABCD || bus.sel !== 1'b0) begin
            failures++;
            $display("FAIL single_drain: valid=%b data=%h sel=%b required 0/abcd/0",
                     bus.y_valid, bus.y_data, bus.sel);
        end
    endtask

    task automatic test_contention();
        logic [15:0] exp_data [4] = '{16'hA000, 16'hB001, 16'hA002, 16'hB003};
        logic        exp_sel  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int n = 0; n < 4; n++) begin
            bus.a_valid = 1'b1;
            bus.b_valid = 1'b1;
            bus.a_data  = 16'hA000 + 16'(n);
            bus.b_data  = 16'hB000 + 16'(n);
            #1;
            checks++;
            if (bus.a_ready !== exp_sel[n] || bus.b_ready !== !exp_sel[n]) begin
                failures++;
                $display("FAIL contend_ready[%0d]: a_ready=%b b_ready=%b required %b/%b",
                         n, bus.a_ready, bus.b_ready, exp_sel[n], !exp_sel[n]);
            end
            step();
            checks++;
            if (bus.y_valid !== 1'b1 || bus.y_data !== exp_data[n] || bus.sel !== exp_sel[n])
            begin
                failures++;
                $display("FAIL contend_out[%0d]: valid=%b data=%h sel=%b required 1/%h/%b",
                         n, bus.y_valid, bus.y_data, bus.sel, exp_data[n], exp_sel[n]);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_backpressure();
        // Priority currently favours a (last grant was b); a alone wins anyway.
        bus.a_valid = 1'b1;
        bus.a_data  = 16'h5555;
        step();
        bus.y_ready = 1'b0;
        bus.a_data  = 16'h6666;
        bus.b_valid = 1'b1;
        bus.b_data  = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_ready[%0d]: a_ready=%b b_ready=%b required 0/0",
                         i, bus.a_ready, bus.b_ready);
            end
            step();
            checks++;
            if (bus.y_valid !== 1'b1 || bus.y_data !== 16'h5555 || bus.sel !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%h sel=%b required 1/5555/1",
                         i, bus.y_valid, bus.y_data, bus.sel);
            end
        end
        bus.y_ready = 1'b1;
        #1;
        checks++;
        if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_ready: a_ready=%b b_ready=%b required 0/1",
                     bus.a_ready, bus.b_ready);
        end
        step();
        idle_inputs();
        checks++;
        if (bus.y_valid !== 1'b1 || bus.y_data !== 16'h7777 || bus.sel !== 1'b0) begin
            failures++;
            $display("FAIL release_out: valid=%b data=%h sel=%b required 1/7777/0",
                     bus.y_valid, bus.y_data, bus.sel);
        end
        step();
    endtask

    task automatic test_idle_priority();
        bus.a_valid = 1'b1;
        bus.a_data  = 16'h0A0A;
        step();
        idle_inputs();
        step();
        step();
        checks++;
        if (bus.y_valid !== 1'b0 || bus.y_data !== 16'h0A0A || bus.sel !== 1'b1) begin
            failures++;
            $display("FAIL idle_hold: valid=%b data=%h sel=%b required 0/0a0a/1",
                     bus.y_valid, bus.y_data, bus.sel);
        end
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        bus.a_data  = 16'hC0C0;
        bus.b_data  = 16'hD0D0;
        step();
        idle_inputs();
        checks++;
        if (bus.y_valid !== 1'b1 || bus.y_data !== 16'hD0D0 || bus.sel !== 1'b0) begin
            failures++;
            $display("FAIL idle_priority: valid=%b data=%h sel=%b required 1/d0d0/0",
                     bus.y_valid, bus.y_data, bus.sel);
        end
        step();
    endtask

    task automatic test_reset_midstream();
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        bus.a_data  = 16'hE001;
        bus.b_data  = 16'hF001;
        step();
        checks++;
        if (bus.y_data !== 16'hE001 || bus.sel !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre: data=%h sel=%b required e001/1", bus.y_data, bus.sel);
        end
        // Without reset the next contention would go to b.
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.y_valid !== 1'b0 || bus.y_data !== 16'h0000 || bus.sel !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: valid=%b data=%h sel=%b required 0/0000/0",
                     bus.y_valid, bus.y_data, bus.sel);
        end
        step();
        checks++;
        if (bus.y_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_edge: valid=%b required 0", bus.y_valid);
        end
        rst = 1'b0;
        bus.a_data = 16'hE002;
        bus.b_data = 16'hF002;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_post_ready: a_ready=%b b_ready=%b required 1/0",
                     bus.a_ready, bus.b_ready);
        end
        step();
        idle_inputs();
        checks++;
        if (bus.y_valid !== 1'b1 || bus.y_data !== 16'hE002 || bus.sel !== 1'b1) begin
            failures++;
            $display("FAIL mid_post_out: valid=%b data=%h sel=%b required 1/e002/1",
                     bus.y_valid, bus.y_data, bus.sel);
        end
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_inputs();
        bus.y_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (bus.y_valid !== 1'b0 || bus.y_data !== 16'h0000 || bus.sel !== 1'b0) begin
            failures++;
            $display("FAIL initial_reset: valid=%b data=%h sel=%b required 0/0000/0",
                     bus.y_valid, bus.y_data, bus.sel);
        end
        step();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_idle_priority();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
